llc_bufs_ctrl: RTL
==================

// Module: llc_bufs_ctrl
// PURPOSE
//  Sequencer/arbiter for the LLC per-set buffer bank (llc_bufs). Decides when a set is loaded
//  from the LLC memories (rd_mem_en), holds ownership of the loaded set until processing ends,
//  and shares the single buffer write port (way + write enables) between memory responses
//  and the processing FSM. Also drives the buffer flush (rst_state) sequence.
// PARAMETERS
//  WAYS      16  number of LLC ways (matches `LLC_WAYS)
//  WAY_BITS   4  width of way index, = $clog2(WAYS)
//  STAT_W    16  width of each statistics counter (LLC_BUF_STATS_EN only)
// PORTS
//  clk                     in   1         clock
//  rst                     in   1         reset, asynchronous, active-low
//  fifo_decoder_mem_empty  in   1         decoder->mem FIFO empty
//  fifo_full_lookup        in   1         lookup FIFO full
//  fifo_full_proc          in   1         proc FIFO full
//  look                    in   1         look bit of decoder->mem FIFO head packet
//  set_done                in   1         processing FSM finished with the loaded set
//  rst_state_req           in   1         request to flush all set buffers
//  mem_rsp_valid           in   1         memory response line available
//  mem_rsp_way             in   WAY_BITS  destination way of memory response
//  proc_wr_valid           in   1         processing FSM buffer write request
//  proc_wr_way             in   WAY_BITS  destination way of processing write
//  proc_wr_mask            in   7         {dirty,hprots,sharers,owners,states,tags,lines}
//  proc_evict_incr         in   1         request to advance evict_way_buf
//  rd_mem_en               out  1         load set into buffers / pop decoder->mem FIFO
//  rst_state               out  1         clear all set buffers
//  llc_mem_rsp_ready_int   out  1         memory response accepted this cycle
//  proc_wr_ready           out  1         processing write accepted this cycle
//  way                     out  WAY_BITS  way index for the granted write
//  wr_en_mask              out  7         buffer write enables, same bit order as proc_wr_mask
//  incr_evict_way_buf      out  1         advance evict_way_buf
//  buf_busy                out  1         a set is owned (state ACTIVE)
// BEHAVIOUR
//  Reset: state=IDLE, rr_ptr=MEM, all outputs 0. Outputs are combinational from state + inputs.
//  FSM states: IDLE, ACTIVE, FLUSH.
//  - rst_state_req=1 in any state -> next state FLUSH; the req has priority over everything.
//    While req=1 no rd_mem_en, no grants, no incr.
//  - FLUSH: rst_state=1 for every cycle in FLUSH. Stays in FLUSH while req=1, else -> IDLE.
//    A set held in ACTIVE is abandoned.
//  - IDLE: rd_mem_en = !empty & !full_lookup & !full_proc & !rst_state_req (0-cycle latency).
//    When rd_mem_en=1 and look=1 -> ACTIVE; when look=0 (pass-through packet) stay IDLE.
//    A new rd_mem_en is possible every cycle.
//  - ACTIVE: rd_mem_en=0, buf_busy=1. One write grant per cycle:
//    * only mem_rsp_valid: llc_mem_rsp_ready_int=1, way=mem_rsp_way, wr_en_mask=0
//      (the line is written by the response handshake itself).
//    * only proc_wr_valid: proc_wr_ready=1, way=proc_wr_way, wr_en_mask=proc_wr_mask.
//    * both: grant the side selected by rr_ptr. After any grant, rr_ptr points to the
//      other side. Worst-case wait is 1 cycle.
//    * no grant: way=0, wr_en_mask=0.
//    incr_evict_way_buf=proc_evict_incr (ACTIVE only; ignored in IDLE and FLUSH).
//    set_done=1 -> IDLE next cycle. A grant or incr in that same cycle is still issued.
//    rd_mem_en is not raised before the following cycle.
//  Grants and ready are never asserted outside ACTIVE; requesters hold valid until ready.
//  mem_rsp and proc write are never both granted, so the two can never collide in llc_bufs.
// CONFIGURATION
//  LLC_BUF_STATS_EN defined: extra outputs stat_loads, stat_stalls, stat_conflicts
//  (STAT_W each). They count, respectively:
//   - rd_mem_en&look cycles;
//   - IDLE cycles with !empty and a full downstream FIFO;
//   - ACTIVE cycles with both requests valid.
//  Counters saturate at all-ones and are cleared only by rst (FLUSH does not clear them).
//  Undefined: ports and counters absent; the remaining behaviour is identical.
// TESTING
//  1. Reset mid-ACTIVE with mem_rsp_valid=1 -> all outputs 0 immediately, state IDLE after release.
//  2. IDLE, nonempty, look=1, FIFOs free -> rd_mem_en=1 same cycle, buf_busy=1 next cycle.
//     Same with look=0 -> stays IDLE, rd_mem_en=1 on back-to-back cycles.
//  3. IDLE, nonempty, fifo_full_proc=1 for 5 cycles -> rd_mem_en=0 throughout.
//     With STATS_EN: stat_stalls=5.
//  4. ACTIVE, mem_rsp_valid and proc_wr_valid held 4 cycles (way 3 / way 9, mask 7'h05)
//     -> grants alternate MEM, PROC, MEM, PROC. way=3,9,3,9. wr_en_mask=0,05,0,05.
//  5. ACTIVE, set_done together with proc_wr_valid -> grant issued that cycle, IDLE next,
//     proc_wr_ready=0 after.
//  6. rst_state_req for 2 cycles during ACTIVE -> rst_state=1 for 2 cycles,
//     then IDLE with buf_busy=0.

Source files
------------

// File: rtl/llc_bufs_ctrl_if.sv
// Handshake bundle between the LLC buffer controller and its requesters.
// master: requester/decoder side, slave: llc_bufs_ctrl.
interface llc_bufs_ctrl_if #(parameter int WAY_BITS = 4);
   logic                fifo_decoder_mem_empty;
   logic                fifo_full_lookup;
   logic                fifo_full_proc;
   logic                look;
   logic                set_done;
   logic                rst_state_req;
   logic                mem_rsp_valid;
   logic [WAY_BITS-1:0] mem_rsp_way;
   logic                proc_wr_valid;
   logic [WAY_BITS-1:0] proc_wr_way;
   logic [6:0]          proc_wr_mask;
   logic                proc_evict_incr;
   logic                rd_mem_en;
   logic                rst_state;
   logic                llc_mem_rsp_ready_int;
   logic                proc_wr_ready;
   logic [WAY_BITS-1:0] way;
   logic [6:0]          wr_en_mask;
   logic                incr_evict_way_buf;
   logic                buf_busy;

   modport master (
      output fifo_decoder_mem_empty, fifo_full_lookup, fifo_full_proc, look, set_done,
             rst_state_req, mem_rsp_valid, mem_rsp_way, proc_wr_valid, proc_wr_way,
             proc_wr_mask, proc_evict_incr,
      input  rd_mem_en, rst_state, llc_mem_rsp_ready_int, proc_wr_ready, way, wr_en_mask,
             incr_evict_way_buf, buf_busy
   );

   modport slave (
      input  fifo_decoder_mem_empty, fifo_full_lookup, fifo_full_proc, look, set_done,
             rst_state_req, mem_rsp_valid, mem_rsp_way, proc_wr_valid, proc_wr_way,
             proc_wr_mask, proc_evict_incr,
      output rd_mem_en, rst_state, llc_mem_rsp_ready_int, proc_wr_ready, way, wr_en_mask,
             incr_evict_way_buf, buf_busy
   );
endinterface

// File: rtl/llc_bufs_ctrl.sv
// LLC per-set buffer bank sequencer: loads a set, owns it until processing is done,
// round-robins the single buffer write port between memory responses and the
// processing FSM, and sequences the buffer flush.
// Optional statistics counters are built when LLC_BUF_STATS_EN is defined.
module llc_bufs_ctrl #(
   parameter int WAYS     = 16,
   parameter int WAY_BITS = $clog2(WAYS),
   parameter int STAT_W   = 16
) (
   input logic            clk,
   input logic            rst,
   llc_bufs_ctrl_if.slave bus
`ifdef LLC_BUF_STATS_EN
   ,
   output logic [STAT_W-1:0] stat_loads,
   output logic [STAT_W-1:0] stat_stalls,
   output logic [STAT_W-1:0] stat_conflicts
`endif
);

   typedef enum logic [1:0] {IDLE, ACTIVE, FLUSH} state_t;
   typedef enum logic {RR_MEM, RR_PROC} rr_t;

   state_t              state, state_nxt;
   rr_t                 rr_ptr, rr_nxt;
   logic                rd_mem_en, rst_state, mem_ready, proc_ready, incr, busy;
   logic [WAY_BITS-1:0] way;
   logic [6:0]          wr_en_mask;
   logic                req;

   assign req = bus.rst_state_req;

   // State and round-robin pointer registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= IDLE;
         rr_ptr <= RR_MEM;
      end else begin
         state  <= state_nxt;
         rr_ptr <= rr_nxt;
      end
   end

   // Next state and outputs; everything is forced low while reset is held
   always_comb begin
      state_nxt  = state;
      rr_nxt     = rr_ptr;
      rd_mem_en  = 1'b0;
      rst_state  = 1'b0;
      mem_ready  = 1'b0;
      proc_ready = 1'b0;
      incr       = 1'b0;
      busy       = 1'b0;
      way        = '0;
      wr_en_mask = '0;
      if (rst) begin
         case (state)
            IDLE: begin
               rd_mem_en = !bus.fifo_decoder_mem_empty && !bus.fifo_full_lookup &&
                           !bus.fifo_full_proc && !req;
               // look=0 packets pass straight through without taking ownership
               if (rd_mem_en && bus.look) state_nxt = ACTIVE;
            end
            ACTIVE: begin
               busy = 1'b1;
               if (!req) begin
                  // Memory wins when alone or when it holds the round-robin turn
                  if (bus.mem_rsp_valid && (!bus.proc_wr_valid || rr_ptr == RR_MEM)) begin
                     mem_ready = 1'b1;
                     way       = bus.mem_rsp_way;
                     rr_nxt    = RR_PROC;
                  end else if (bus.proc_wr_valid) begin
                     proc_ready = 1'b1;
                     way        = bus.proc_wr_way;
                     wr_en_mask = bus.proc_wr_mask;
                     rr_nxt     = RR_MEM;
                  end
                  incr = bus.proc_evict_incr;
                  if (bus.set_done) state_nxt = IDLE;
               end
            end
            FLUSH: begin
               rst_state = 1'b1;
               if (!req) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
         endcase
         // A flush request abandons any owned set
         if (req) state_nxt = FLUSH;
      end
   end

   assign bus.rd_mem_en             = rd_mem_en;
   assign bus.rst_state             = rst_state;
   assign bus.llc_mem_rsp_ready_int = mem_ready;
   assign bus.proc_wr_ready         = proc_ready;
   assign bus.way                   = way;
   assign bus.wr_en_mask            = wr_en_mask;
   assign bus.incr_evict_way_buf    = incr;
   assign bus.buf_busy              = busy;

`ifdef LLC_BUF_STATS_EN
   logic ev_load, ev_stall, ev_conflict;

   assign ev_load     = rd_mem_en && bus.look;
   assign ev_stall    = (state == IDLE) && !bus.fifo_decoder_mem_empty &&
                        (bus.fifo_full_lookup || bus.fifo_full_proc);
   assign ev_conflict = (state == ACTIVE) && bus.mem_rsp_valid && bus.proc_wr_valid;

   // Saturating event counters; only the hard reset clears them
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stat_loads     <= '0;
         stat_stalls    <= '0;
         stat_conflicts <= '0;
      end else begin
         if (ev_load && stat_loads != '1)         stat_loads     <= stat_loads + 1'b1;
         if (ev_stall && stat_stalls != '1)       stat_stalls    <= stat_stalls + 1'b1;
         if (ev_conflict && stat_conflicts != '1) stat_conflicts <= stat_conflicts + 1'b1;
      end
   end
`endif

endmodule
